// File: rtl/fifo_word_packer.sv
// fifo_word_packer
// Pops DATA_WIDTH-bit entries from the byte FIFO (read data arrives the cycle
// after fifo_pop) and packs PACK of them into one output word, lane 0 in the
// LSBs. A flush request emits the current partial word with out_keep marking
// the filled lanes.
//
// Optional feature: define FIFO_WORD_PACKER_TIMEOUT_EN to auto-flush a partial
// word after TIMEOUT idle cycles. Without it, partial words leave only on flush.
//
// Output handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid rises it stays high, and out_data and
// out_keep stay stable, until that transfer happens; out_valid never depends
// combinationally on out_ready.
//
// dbg_state exposes the FSM state: 0 = COLLECT, 1 = EMIT.
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fifo_empty,
  output logic                         fifo_pop,
  input  logic [DATA_WIDTH-1:0]        fifo_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH*PACK-1:0]   out_data,
  output logic [PACK-1:0]              out_keep,
  output logic                         dbg_state
);

  localparam int CW = $clog2(PACK + 1);

  // Reject configurations the packer cannot represent
  if (PACK < 2 || TIMEOUT < 1) begin : g_param_check
    $error("fifo_word_packer: PACK must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;          // lanes already captured
  logic          inflight;       // a pop was issued last cycle; data arrives now
  logic          flush_pending;  // flush requested, waiting for the collector to drain
  logic          flush_late;     // flush seen during EMIT, replayed after the handshake
  logic          capture;
  logic          word_full;
  logic          flush_emit;
  logic          timeout_hit;

  // Capture and emission triggers for this cycle
  always_comb begin
    capture    = (state == COLLECT) && inflight;
    word_full  = capture && (int'(count) + 1 == PACK);
    flush_emit = (state == COLLECT) && flush_pending && !inflight && (count != '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Next state: emit on a completed word or a drained flush, return on handshake
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (word_full || flush_emit) state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // State-derived outputs: pop request (never in EMIT or reset) and debug view
  always_comb begin
    fifo_pop  = rst_n && (state == COLLECT) && !fifo_empty && !flush_pending &&
                (int'(count) + int'(inflight) < PACK);
    dbg_state = (state == EMIT);
  end

  // Lane capture, flush bookkeeping and word hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_keep      <= '0;
      count         <= '0;
      inflight      <= 1'b0;
      flush_pending <= 1'b0;
      flush_late    <= 1'b0;
    end else begin
      out_valid <= (state_nxt == EMIT);
      if (state == COLLECT) begin
        inflight <= fifo_pop;
        if (capture) begin
          for (int i = 0; i < PACK; i++) begin
            if (int'(count) == i) begin
              out_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
              out_keep[i]                          <= 1'b1;
            end
          end
          count <= count + CW'(1);
        end
        if (flush || timeout_hit) begin
          flush_pending <= 1'b1;
        end else if (flush_pending && !inflight && (count == '0)) begin
          // Nothing collected and nothing arriving: the flush is a no-op
          flush_pending <= 1'b0;
        end
      end else begin
        inflight <= 1'b0;
        if (out_ready) begin
          // Clear all lanes so the next partial word has zero unused lanes
          out_data      <= '0;
          out_keep      <= '0;
          count         <= '0;
          flush_pending <= flush_late | flush;
          flush_late    <= 1'b0;
        end else if (flush) begin
          flush_late <= 1'b1;
        end
      end
    end
  end

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_cnt;
  logic          idle;

  assign idle        = (state == COLLECT) && (count != '0) && !inflight && !fifo_pop;
  assign timeout_hit = idle && (int'(idle_cnt) == TIMEOUT - 1);

  // Idle counter: restarts on any pop or capture, clears when it fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   idle_cnt <= '0;
    else if (!idle || timeout_hit) idle_cnt <= '0;
    else                          idle_cnt <= idle_cnt + TW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Downstream consumer of the team's synchronous byte FIFO. It pops DATA_WIDTH-bit entries through the FIFO's pop/empty/data_out interface, where read data is registered one cycle after pop. It packs PACK entries into one wide word and presents it on a valid/ready output stream. Partial words are emitted on request via flush, with out_keep marking the valid lanes.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry / one lane
PACK, 4, lanes per output word (>=2)
TIMEOUT, 16, idle cycles before auto-flush (used only with the optional feature; >=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fifo_empty  in  1  FIFO empty flag
fifo_pop  out  1  pop request to FIFO
fifo_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_pop
flush  in  1  single-cycle request to emit the current partial word
out_valid  out  1  packed word available
out_ready  in  1  sink accepts word
out_data  out  DATA_WIDTH*PACK  packed word; lane 0 in the LSBs
out_keep  out  PACK  bit i = lane i holds valid data

Behaviour:
- Reset values: out_valid=0, out_data=0, out_keep=0, count=0, inflight=0, flush_pending=0, state=COLLECT. fifo_pop is 0 while rst_n=0.
- State COLLECT:
  - fifo_pop = !fifo_empty && !flush_pending && (count+inflight) < PACK. fifo_pop is combinational from registers and fifo_empty.
  - inflight <= fifo_pop.
  - When inflight=1, fifo_data is written into lane[count], count increments, and keep bit [count] is set.
  - Lanes fill strictly in pop order: lane 0 first.
- COLLECT -> EMIT:
  - When a capture makes count==PACK: out_keep = all ones.
  - When flush_pending=1 && inflight=0 && count>0: out_keep = ones in bits [count-1:0].
  - In both cases out_valid=1 in the next cycle.
  - Unused lanes of out_data are driven 0.
- State EMIT:
  - fifo_pop=0.
  - out_data and out_keep are held stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: out_valid<=0, count<=0, keep<=0, flush_pending<=0, return to COLLECT. Pops may resume the following cycle.
- Flush:
  - flush=1 sets flush_pending and stops new pops.
  - A pop already in flight is captured before emission.
  - If flush_pending=1 with count==0 && inflight==0, flush_pending clears with no output.
  - flush asserted during EMIT is recorded and applies after the handshake.
- Latency and throughput:
  - A non-empty FIFO with out_ready held at 1 yields a full word PACK+1 cycles after the first pop.
  - The minimum spacing is PACK+2 cycles per word.
- Boundaries:
  - fifo_empty rising mid-word pauses popping and holds the partial lanes.
  - The block never pops in EMIT, so no FIFO data is lost under backpressure.
  - Reset mid-word discards partial lanes and any inflight capture.
  - count never exceeds PACK.

Optional Feature:
Macro: FIFO_WORD_PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in COLLECT while count>0 and inflight=0 and fifo_pop=0.
  - Any pop or capture resets it to 0.
  - On reaching TIMEOUT it sets flush_pending, which emits the partial word, then resets.
- Not defined:
  - No counter exists and TIMEOUT is unused.
  - Partial words leave only via explicit flush.

Test Plan:
- PACK=4; FIFO preloaded with 0x11,0x22,0x33,0x44; out_ready=1 -> one word out_data=0x44332211, out_keep=4'b1111, 4 pops total, out_valid pulses 1 cycle.
- 8 entries 0x01..0x08; out_ready=0 for 20 cycles, then 1 -> out_data=0x04030201 held stable with fifo_pop=0 throughout the stall; second word is 0x08070605.
- Push 0xAA,0xBB, then FIFO empty; pulse flush -> out_data=0x0000BBAA, out_keep=4'b0011; flush with empty collector -> no out_valid.
- flush in the cycle after the 3rd pop (inflight=1) -> the 3rd byte is captured; out_keep=4'b0111.
- Assert rst_n=0 mid-word with count=2 -> out_valid=0, out_keep=0, fifo_pop=0 during reset; next word starts at lane 0.
- With FIFO_WORD_PACKER_TIMEOUT_EN, TIMEOUT=16, one entry 0x5A -> out_valid 17 cycles after capture, out_data=0x0000005A, out_keep=4'b0001. Without the macro -> no output.
